// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEF_WIDTH = 4;

    // Wide enough for any practical WIDTH; users slice the low WIDTH bits.
    localparam logic [31:0] DIV0_QUOTIENT = '1;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] divisor_ext;

    // One extra bit so the shifted remainder can exceed any WIDTH-bit divisor.
    always_comb begin
        trial       = {r_in, q_msb};
        divisor_ext = {1'b0, divisor};
        q_bit       = (trial >= divisor_ext);
        r_out       = q_bit ? WIDTH'(trial - divisor_ext) : trial[WIDTH-1:0];
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | WIDTH shift/trial-subtract steps, counter counts down to 0
// DONE  | one-cycle done pulse, results valid
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH-1:0] step_r;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in    (r_q),
        .q_msb   (q_q[WIDTH-1]),
        .divisor (dvs_q),
        .r_out   (step_r),
        .q_bit   (step_bit)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        r_d           = r_q;
        q_d           = q_q;
        dvs_d         = dvs_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        quotient_d    = DIV0_QUOTIENT[WIDTH-1:0];
                        remainder_d   = dividend;
                        div_by_zero_d = 1'b1;
                        state_d       = DONE;
                    end else begin
                        div_by_zero_d = 1'b0;
                        cnt_d         = CNT_W'(WIDTH);
                        r_d           = '0;
                        q_d           = dividend;
                        state_d       = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = {q_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q - CNT_W'(1);
                // Last step: publish the freshly computed bits, not the stale shift register.
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = {q_q[WIDTH-2:0], step_bit};
                    remainder_d = step_r;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            r_q           <= '0;
            q_q           <= '0;
            dvs_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            r_q           <= r_d;
            q_q           <= q_d;
            dvs_q         <= dvs_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule : seq_divider

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse companion to the 4x4 array multiplier.
- Produces one quotient bit per clock using a shift/trial-subtract datapath, with a start/busy/done handshake.
- Used standalone and as a checker for multiplier results: (A*B)/B == A.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned numerator; captured on the accepting edge.
- divisor  input  WIDTH  unsigned denominator; captured on the accepting edge.
- busy  output  1  high while a division is in progress (RUN state).
- done  output  1  single-cycle pulse; results valid.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  set with done when the captured divisor == 0.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE; busy, done, div_by_zero, quotient, remainder all 0; internal counter and registers 0.
- States:
  - IDLE: on the edge where start=1 (acceptance edge E0), latch dividend and divisor.
    - Divisor != 0: go to RUN, load counter=WIDTH, partial remainder R=0, shift register Q=dividend.
    - Divisor == 0: go to DONE directly. quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - RUN: each edge performs one step:
    - T = {R, Q[MSB]} (WIDTH+1 bits).
    - If T >= {0, divisor}: R=T-divisor, shift 1 into Q LSB; else R=T[WIDTH-1:0], shift 0.
    - Counter decrements. On the edge where counter reaches 0 (edge E_WIDTH), register quotient=Q_next and remainder=R_next, then go to DONE.
  - DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Timing:
  - busy=1 exactly during RUN, i.e. WIDTH cycles.
  - done is high in the cycle after edge E_WIDTH (the cycle after E0 for divide-by-zero).
  - busy and done are never high together.
- Outputs: quotient, remainder and div_by_zero hold their values until the next accepted start. div_by_zero clears on the next acceptance with a nonzero divisor.
- Input changes: start asserted in RUN or DONE is ignored and not queued. Changes to dividend or divisor after E0 do not affect the result.
- Back-to-back operation: start held high continuously gives a new acceptance on the first IDLE edge after DONE (period WIDTH+2 cycles).
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse for the aborted operation.
- Width rules:
  - Trial subtract uses WIDTH+1 bits to avoid overflow.
  - Invariant for divisor != 0: dividend == quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Shared package div_pkg holds:
  - state enum: IDLE, RUN, DONE;
  - default WIDTH constant;
  - DIV0_QUOTIENT constant (all ones).
- One natural combinational sub-module, div_step. Inputs: R, Q MSB, divisor. Outputs: next R and quotient bit. This keeps the FSM and counter in seq_divider and lets div_step be unrolled later for a combinational array divider.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start pulse at E0:
  - busy high 4 cycles;
  - done in the cycle after E4;
  - quotient=4, remainder=1, div_by_zero=0.
- 15/1 -> quotient=15, remainder=0. 7/9 -> quotient=0, remainder=7. 0/5 -> quotient=0, remainder=0.
- 9/0 -> done in the cycle after E0, busy never high, quotient=15, remainder=9, div_by_zero=1. A following 8/2 -> quotient=4, remainder=0, div_by_zero=0.
- 12/5 accepted; at cycle 2 of RUN apply start=1 with 6/3 and change the inputs -> result stays quotient=2, remainder=2; a single done pulse; the second start is not serviced.
- Assert rst_n=0 during cycle 2 of RUN -> all outputs 0 immediately. After release, a fresh 10/4 -> quotient=2, remainder=2.
- Exhaustive sweep of all 256 dividend/divisor pairs with start held high:
  - divisor != 0: quotient == dividend/divisor and remainder == dividend%divisor;
  - divisor == 0: divide-by-zero response as above;
  - done spacing of 6 cycles for nonzero divisors.
